sdram_init_refresh_sched: RTL and testbench

// - Owns the SDRAM command bus after power-up: runs the JEDEC init sequence, then schedules periodic

---
 rtl/sdram_pkg.sv | 31 +++
 rtl/sdram_refresh_timer.sv | 46 ++++
 rtl/sdram_init_refresh_sched.sv | 133 +++++++++++++
 tb/tb_sdram_init_refresh_sched.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - SDRAM command encodings, scheduler states and wait helper
package sdram_pkg;

    localparam logic [3:0] CMD_INHIBIT   = 4'b1111;
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_MRS       = 4'b0000;

    typedef enum logic [3:0] {
        ST_INIT_WAIT,
        ST_INIT_PRE,
        ST_INIT_RP,
        ST_INIT_REF1,
        ST_INIT_RFC1,
        ST_INIT_REF2,
        ST_INIT_RFC2,
        ST_INIT_MRS,
        ST_INIT_MRD,
        ST_IDLE,
        ST_GRANT,
        ST_REF,
        ST_REF_WAIT
    } sched_state_t;

    // Last cycle of a NOP wait state that lasts t_cyc-1 cycles (the command cycle counts as one).
    function automatic logic wait_last(input logic [15:0] cnt, input int t_cyc);
        return (int'(cnt) + 2) >= t_cyc;
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// rtl/sdram_refresh_timer.sv - refresh interval counter with saturating owed-refresh count
module sdram_refresh_timer #(
    parameter int REFRESH_CYC = 780,
    parameter int MAX_OWED    = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic consume,
    output logic owed_nz
);

    localparam int TW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
    localparam int OW = $clog2(MAX_OWED + 1);
    localparam logic [TW-1:0] RELOAD   = TW'(REFRESH_CYC - 1);
    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic [OW-1:0] OWED_MAX = OW'(MAX_OWED);
    localparam logic [OW-1:0] O_ONE    = OW'(1);

    logic [TW-1:0] timer;
    logic [OW-1:0] owed;
    logic          tick;
    logic          take;

    assign tick    = enable && (timer == '0);
    assign take    = consume && (owed != '0);
    assign owed_nz = (owed != '0);

    // A tick and a consume in the same cycle cancel; ticks beyond MAX_OWED are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer <= RELOAD;
            owed  <= '0;
        end else begin
            if (enable) begin
                timer <= tick ? RELOAD : timer - T_ONE;
            end
            if (tick && !take && (owed != OWED_MAX)) begin
                owed <= owed + O_ONE;
            end else if (take && !tick) begin
                owed <= owed - O_ONE;
            end
        end
    end

endmodule

// File: rtl/sdram_init_refresh_sched.sv
// rtl/sdram_init_refresh_sched.sv - SDRAM power-up init, refresh scheduling and client bus grant
module sdram_init_refresh_sched
    import sdram_pkg::*;
#(
    parameter int          INIT_WAIT_CYC = 20000,
    parameter int          REFRESH_CYC   = 780,
    parameter int          T_RP          = 2,
    parameter int          T_RFC         = 7,
    parameter int          T_MRD         = 2,
    parameter logic [12:0] MODE_REG      = 13'h020,
    parameter int          MAX_OWED      = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        ready,
    input  logic        client_req,
    output logic        client_ack,
    input  logic        client_done,
    output logic        bus_owner,
    output logic        sd_cke,
    output logic [3:0]  sd_cmd,
    output logic [12:0] sd_addr,
    output logic [1:0]  sd_ba,
    output logic        refresh_due
);

    sched_state_t state;
    sched_state_t state_nxt;
    logic [15:0]  wait_cnt;
    logic         cke_q;
    logic         consume;
    logic         owed_nz;

    sdram_refresh_timer #(
        .REFRESH_CYC (REFRESH_CYC),
        .MAX_OWED    (MAX_OWED)
    ) u_refresh_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (ready),
        .consume (consume),
        .owed_nz (owed_nz)
    );

    assign ready       = state inside {ST_IDLE, ST_GRANT, ST_REF, ST_REF_WAIT};
    assign bus_owner   = (state == ST_GRANT);
    assign refresh_due = owed_nz;
    assign sd_cke      = cke_q;
    assign sd_ba       = 2'b00;

    // wait_cnt restarts on every state change so all wait states share it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_INIT_WAIT;
            wait_cnt <= '0;
            cke_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            cke_q <= 1'b1;
            if (state_nxt != state) begin
                wait_cnt <= '0;
            end else if (wait_cnt != '1) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        sd_cmd     = CMD_NOP;
        sd_addr    = '0;
        client_ack = 1'b0;
        consume    = 1'b0;
        case (state)
            ST_INIT_WAIT: begin
                sd_cmd = CMD_INHIBIT;
                if (wait_cnt == 16'(INIT_WAIT_CYC)) state_nxt = ST_INIT_PRE;
            end
            ST_INIT_PRE: begin
                sd_cmd    = CMD_PRECHARGE;
                sd_addr   = 13'h0400;
                state_nxt = ST_INIT_RP;
            end
            ST_INIT_RP: begin
                if (wait_last(wait_cnt, T_RP)) state_nxt = ST_INIT_REF1;
            end
            ST_INIT_REF1: begin
                sd_cmd    = CMD_REFRESH;
                state_nxt = ST_INIT_RFC1;
            end
            ST_INIT_RFC1: begin
                if (wait_last(wait_cnt, T_RFC)) state_nxt = ST_INIT_REF2;
            end
            ST_INIT_REF2: begin
                sd_cmd    = CMD_REFRESH;
                state_nxt = ST_INIT_RFC2;
            end
            ST_INIT_RFC2: begin
                if (wait_last(wait_cnt, T_RFC)) state_nxt = ST_INIT_MRS;
            end
            ST_INIT_MRS: begin
                sd_cmd    = CMD_MRS;
                sd_addr   = MODE_REG;
                state_nxt = ST_INIT_MRD;
            end
            ST_INIT_MRD: begin
                if (wait_last(wait_cnt, T_MRD)) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                // Owed refresh wins over a simultaneous client request.
                if (owed_nz) begin
                    consume   = 1'b1;
                    state_nxt = ST_REF;
                end else if (client_req) begin
                    client_ack = 1'b1;
                    state_nxt  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (client_done) state_nxt = ST_IDLE;
            end
            ST_REF: begin
                sd_cmd    = CMD_REFRESH;
                state_nxt = ST_REF_WAIT;
            end
            ST_REF_WAIT: begin
                if (wait_last(wait_cnt, T_RFC)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_INIT_WAIT;
        endcase
    end

endmodule

// File: tb/tb_sdram_init_refresh_sched.sv
// tb/tb_sdram_init_refresh_sched.sv - self-checking bench for the SDRAM init/refresh scheduler
module tb_sdram_init_refresh_sched;

    localparam int RC   = 20;
    localparam int TRFC = 3;
    localparam int MAXO = 3;

    localparam logic [3:0] C_INH = 4'b1111;
    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_MRS = 4'b0000;

    typedef struct {
        logic        req;
        logic        done;
        logic [3:0]  cmd;
        logic [12:0] addr;
        logic        cke;
        logic        rdy;
    } init_vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        client_req;
    logic        client_done;
    logic        ready;
    logic        client_ack;
    logic        bus_owner;
    logic        sd_cke;
    logic [3:0]  sd_cmd;
    logic [12:0] sd_addr;
    logic [1:0]  sd_ba;
    logic        refresh_due;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_ack_cyc = -1;
    int k;
    bit hold;
    logic rd;

    init_vec_t tbl [21];

    int m_owed, m_tmr, m_nop;
    bit m_ref, m_gnt, m_ack;

    logic [3:0] cmd_log [1024];
    logic       own_log [1024];
    logic       due_log [1024];
    logic       ack_log [1024];

    always #5 clk = ~clk;

    sdram_init_refresh_sched #(
        .INIT_WAIT_CYC (10),
        .REFRESH_CYC   (RC),
        .T_RP          (2),
        .T_RFC         (TRFC),
        .T_MRD         (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ready       (ready),
        .client_req  (client_req),
        .client_ack  (client_ack),
        .client_done (client_done),
        .bus_owner   (bus_owner),
        .sd_cke      (sd_cke),
        .sd_cmd      (sd_cmd),
        .sd_addr     (sd_addr),
        .sd_ba       (sd_ba),
        .refresh_due (refresh_due)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d act=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic log_cycle();
        if (cyc < 1024) begin
            cmd_log[cyc] = sd_cmd;
            own_log[cyc] = bus_owner;
            due_log[cyc] = refresh_due;
            ack_log[cyc] = client_ack;
        end
        if (client_ack === 1'b1) last_ack_cyc = cyc;
    endtask

    function automatic int count_ref(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (cmd_log[i] === C_REF) n++;
        return n;
    endfunction

    task automatic init_model();
        m_owed = 0;
        m_tmr  = RC - 1;
        m_nop  = 0;
        m_ref  = 1'b0;
        m_gnt  = 1'b0;
        m_ack  = 1'b0;
    endtask

    // Power-up sequence checked against the fixed table, cycles 0..20 after reset release.
    task automatic run_init();
        for (int i = 0; i < 21; i++) begin
            client_req  = tbl[i].req;
            client_done = tbl[i].done;
            #1;
            log_cycle();
            check("init_seq",
                  {8'd0, ready, sd_cke, bus_owner, client_ack, refresh_due, sd_cmd, sd_addr, sd_ba},
                  {8'd0, tbl[i].rdy, tbl[i].cke, 3'b000, tbl[i].cmd, tbl[i].addr, 2'b00});
            cyc++;
            @(negedge clk);
        end
    endtask

    // One post-init cycle: drive inputs, compare to the behavioural model, advance the model.
    task automatic step(input logic req, input logic done);
        bit         idle, tick, cons, eack, eown;
        logic [3:0] ecmd;
        client_req  = req;
        client_done = done;
        #1;
        log_cycle();
        idle = !m_ref && (m_nop == 0) && !m_gnt;
        ecmd = m_ref ? C_REF : C_NOP;
        eown = m_gnt;
        eack = idle && (m_owed == 0) && req;
        check("sched",
              {8'd0, ready, sd_cke, bus_owner, client_ack, refresh_due, sd_cmd, sd_addr, sd_ba},
              {8'd0, 1'b1, 1'b1, eown, eack, (m_owed != 0), ecmd, 13'd0, 2'b00});
        tick  = (m_tmr == 0);
        m_tmr = tick ? RC - 1 : m_tmr - 1;
        cons  = idle && (m_owed != 0);
        m_owed = m_owed + (tick ? 1 : 0) - (cons ? 1 : 0);
        if (m_owed > MAXO) m_owed = MAXO;
        if (m_ref) m_nop = TRFC - 1;
        else if (m_nop > 0) m_nop--;
        m_ref = cons;
        if (eack) m_gnt = 1'b1;
        else if (m_gnt && done) m_gnt = 1'b0;
        m_ack = eack;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 21; i++) begin
            tbl[i].req  = (i >= 5);
            tbl[i].done = (i == 8);
            tbl[i].cmd  = (i <= 10) ? C_INH : C_NOP;
            tbl[i].addr = 13'd0;
            tbl[i].cke  = (i != 0);
            tbl[i].rdy  = 1'b0;
        end
        tbl[11].cmd = C_PRE;  tbl[11].addr = 13'h0400;
        tbl[13].cmd = C_REF;
        tbl[16].cmd = C_REF;
        tbl[19].cmd = C_MRS;  tbl[19].addr = 13'h020;

        reset_n     = 1'b0;
        client_req  = 1'b0;
        client_done = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_state",
              {8'd0, ready, sd_cke, bus_owner, client_ack, refresh_due, sd_cmd, sd_addr, sd_ba},
              {8'd0, 5'b00000, C_INH, 13'd0, 2'b00});
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
        run_init();
        init_model();

        // Request held across ready: grant, then release 5 cycles after the ack.
        step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        while (cyc < 101) step(1'b0, 1'b0);
        check("ack_at_ready", 32'(ack_log[21]), 32'd1);
        check("owner_start", 32'(own_log[22]), 32'd1);
        check("owner_at_done", 32'(own_log[26]), 32'd1);
        check("owner_released", 32'(own_log[27]), 32'd0);
        check("idle_ref_count", 32'(count_ref(21, 100)), 32'd3);
        check("ref_at_42", 32'(cmd_log[42]), 32'(C_REF));
        check("ref_at_62", 32'(cmd_log[62]), 32'(C_REF));
        check("ref_at_82", 32'(cmd_log[82]), 32'(C_REF));
        check("due_pulse", {29'd0, due_log[40], due_log[41], due_log[42]}, 32'b010);

        // Request arrives in the cycle the tick lands: refresh first, then ack.
        k = 0;
        do begin
            step(1'b1, 1'b0);
            k++;
        end while (!m_ack && k < 20);
        check("tick_req_ref_first", 32'(cmd_log[102]), 32'(C_REF));
        check("tick_req_ack_cycle", 32'(last_ack_cyc), 32'd105);

        // Long grant: owed saturates, then back-to-back refreshes after release.
        while (cyc < 190) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        while (cyc < 215) step(1'b0, 1'b0);
        check("no_ref_in_grant", 32'(count_ref(106, 190)), 32'd0);
        check("long_grant_owner", {30'd0, own_log[190], own_log[191]}, 32'b10);
        check("burst_refs", 32'(count_ref(191, 200)), 32'd3);
        check("burst_spacing",
              {20'd0, cmd_log[192], cmd_log[196], cmd_log[200]}, {20'd0, C_REF, C_REF, C_REF});
        check("burst_total", 32'(count_ref(191, 214)), 32'd4);

        hold = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!hold && $urandom_range(0, 4) == 0) hold = 1'b1;
            rd = m_gnt ? ($urandom_range(0, 6) == 0) : ($urandom_range(0, 19) == 0);
            step(hold, rd);
            if (m_ack) hold = 1'b0;
        end

        // Reset while granted, then a full init replay.
        k = 0;
        do begin
            step(1'b1, 1'b0);
            k++;
        end while (!m_ack && k < 40);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("owner_before_reset", 32'(bus_owner), 32'd1);
        reset_n    = 1'b0;
        client_req = 1'b0;
        #1;
        check("async_reset",
              {8'd0, ready, sd_cke, bus_owner, client_ack, refresh_due, sd_cmd, sd_addr, sd_ba},
              {8'd0, 5'b00000, C_INH, 13'd0, 2'b00});
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
        run_init();
        init_model();
        step(1'b1, 1'b0);
        check("replay_ack", 32'(ack_log[21]), 32'd1);
        repeat (3) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (30) step(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
